// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and the duty saturation helper for the prescaled PWM generator.
package pwm_pkg;
  localparam int DIV_DEF = 4;
  localparam int PERIOD_DEF = 16;
  function automatic int sat_duty(input int duty, input int period);
    return duty > period ? period : duty;
  endfunction
endpackage

// File: rtl/slow_tick_gen.sv
// slow_tick_gen: prescaler producing a one-cycle clock-enable strobe every DIV enabled clk cycles.
module slow_tick_gen
  import pwm_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  logic last, tick_q;
  assign last = cnt == CW'(DIV - 1);
  // a tick pending when en_i drops is held and released on re-enable, so pausing never stretches a period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      tick_q <= 1'b0;
    end else if (en_i) begin
      cnt <= last ? '0 : cnt + 1'b1;
      tick_q <= last;
    end
  assign tick_o = tick_q & en_i;
endmodule

// File: rtl/pwm_slow_gen.sv
// pwm_slow_gen: prescaled PWM generator with registered output and tick/wrap strobes.
// PWM_SHADOW_EN: duty_i is captured only at period start (glitch-free periods); otherwise every cycle.
module pwm_slow_gen
  import pwm_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter int PERIOD = PERIOD_DEF,
  localparam int DUTY_W = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_o,
  output logic              tick_o,
  output logic              wrap_o
);
  logic tick;
  logic [DUTY_W-1:0] pcnt, duty_r, duty_s;
  slow_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .tick_o(tick)
  );
  assign tick_o = tick;
  assign wrap_o = tick && pcnt == DUTY_W'(PERIOD - 1);
  assign duty_s = DUTY_W'(sat_duty(int'(duty_i), PERIOD));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      pwm_o <= 1'b0;
    end else begin
      if (tick) pcnt <= wrap_o ? '0 : pcnt + 1'b1;
      pwm_o <= en_i && pcnt < duty_r;
    end
`ifdef PWM_SHADOW_EN
  logic first;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty_r <= '0;
      first <= 1'b1;
    end else if (en_i && (first || wrap_o)) begin
      duty_r <= duty_s;
      first <= 1'b0;
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) duty_r <= '0;
    else duty_r <= duty_s;
`endif
endmodule

// File: tb/tb_pwm_slow_gen.sv
// tb_pwm_slow_gen: directed checks of the default configuration plus a DIV=1/PERIOD=2 instance.
module tb_pwm_slow_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [4:0] duty = '0;
  logic [1:0] duty1 = '0;
  logic pwm, tick, wrap, pwm1, tick1, wrap1;
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  pwm_slow_gen u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .duty_i(duty),
    .pwm_o(pwm), .tick_o(tick), .wrap_o(wrap)
  );

  pwm_slow_gen #(.DIV(1), .PERIOD(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .en_i(en), .duty_i(duty1),
    .pwm_o(pwm1), .tick_o(tick1), .wrap_o(wrap1)
  );

  task automatic run_from_reset(input logic [4:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    duty = d;
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b1;
    duty = 5'd8;
    duty1 = 2'd1;
    repeat (2) @(negedge clk);
    vec++; if (pwm !== 1'b0) begin err++; $display("FAIL reset_pwm got %b want 0", pwm); end
    vec++; if (tick !== 1'b0) begin err++; $display("FAIL reset_tick got %b want 0", tick); end
    vec++; if (wrap !== 1'b0) begin err++; $display("FAIL reset_wrap got %b want 0", wrap); end
    vec++; if (pwm1 !== 1'b0) begin err++; $display("FAIL reset_pwm1 got %b want 0", pwm1); end
    vec++; if (tick1 !== 1'b0) begin err++; $display("FAIL reset_tick1 got %b want 0", tick1); end
  endtask

  task automatic test_basic;
    logic et, ew, ep;
    run_from_reset(5'd8);
    for (int c = 1; c <= 192; c++) begin
      @(negedge clk);
      et = (c % 4) == 0;
      ew = (c % 64) == 0;
      ep = c >= 2 && ((c - 2) % 64) < 32;
      vec++; if (tick !== et) begin err++; $display("FAIL basic_tick c=%0d got %b want %b", c, tick, et); end
      vec++; if (wrap !== ew) begin err++; $display("FAIL basic_wrap c=%0d got %b want %b", c, wrap, ew); end
      vec++; if (pwm !== ep) begin err++; $display("FAIL basic_pwm c=%0d got %b want %b", c, pwm, ep); end
    end
  endtask

  task automatic test_boundary;
    int hi;
    run_from_reset(5'd0);
    hi = 0;
    repeat (200) begin @(negedge clk); hi += int'(pwm); end
    vec++; if (hi !== 0) begin err++; $display("FAIL duty0_high got %0d want 0", hi); end
    duty = 5'd16;
    repeat (66) @(negedge clk);
    hi = 0;
    repeat (128) begin @(negedge clk); hi += int'(pwm); end
    vec++; if (hi !== 128) begin err++; $display("FAIL duty16_high got %0d want 128", hi); end
    duty = 5'd20;
    repeat (66) @(negedge clk);
    hi = 0;
    repeat (128) begin @(negedge clk); hi += int'(pwm); end
    vec++; if (hi !== 128) begin err++; $display("FAIL duty20_high got %0d want 128", hi); end
  endtask

  task automatic test_midchange;
    int hi;
    run_from_reset(5'd4);
    hi = 0;
    for (int c = 1; c <= 30; c++) begin @(negedge clk); hi += int'(pwm); end
    vec++; if (hi !== 16) begin err++; $display("FAIL mid_first_high got %0d want 16", hi); end
    duty = 5'd12;
    @(negedge clk);
    vec++; if (pwm !== 1'b0) begin err++; $display("FAIL mid_c31 got %b want 0", pwm); end
    @(negedge clk);
`ifdef PWM_SHADOW_EN
    vec++; if (pwm !== 1'b0) begin err++; $display("FAIL mid_c32_shadow got %b want 0", pwm); end
`else
    vec++; if (pwm !== 1'b1) begin err++; $display("FAIL mid_c32_direct got %b want 1", pwm); end
`endif
    repeat (32) @(negedge clk);
    hi = 0;
    repeat (64) begin @(negedge clk); hi += int'(pwm); end
    vec++; if (hi !== 48) begin err++; $display("FAIL mid_next_high got %0d want 48", hi); end
  endtask

  task automatic test_pause;
    int quiet, n;
    run_from_reset(5'd8);
    repeat (20) @(negedge clk);
    vec++; if (tick !== 1'b1) begin err++; $display("FAIL pause_pre_tick got %b want 1", tick); end
    en = 1'b0;
    quiet = 0;
    repeat (50) begin @(negedge clk); quiet += int'(tick | wrap | pwm); end
    vec++; if (quiet !== 0) begin err++; $display("FAIL pause_quiet got %0d want 0", quiet); end
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        vec++; if (pwm !== 1'b1) begin err++; $display("FAIL pause_resume_pwm got %b want 1", pwm); end
      end
    end while (!wrap && n < 200);
    vec++; if (n !== 44) begin err++; $display("FAIL pause_remainder got %0d want 44", n); end
  endtask

  task automatic test_async_reset;
    int n;
    run_from_reset(5'd8);
    repeat (12) @(negedge clk);
    vec++; if (pwm !== 1'b1) begin err++; $display("FAIL arst_pre_pwm got %b want 1", pwm); end
    vec++; if (tick !== 1'b1) begin err++; $display("FAIL arst_pre_tick got %b want 1", tick); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (pwm !== 1'b0) begin err++; $display("FAIL arst_pwm got %b want 0", pwm); end
    vec++; if (tick !== 1'b0) begin err++; $display("FAIL arst_tick got %b want 0", tick); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick && n < 50);
    vec++; if (n !== 4) begin err++; $display("FAIL arst_first_tick got %0d want 4", n); end
  endtask

  task automatic test_div1;
    logic ep, ew;
    duty1 = 2'd1;
    run_from_reset(5'd8);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ep = c >= 2 && (c % 2) == 0;
      ew = (c % 2) == 0;
      vec++; if (tick1 !== 1'b1) begin err++; $display("FAIL div1_tick c=%0d got %b want 1", c, tick1); end
      vec++; if (pwm1 !== ep) begin err++; $display("FAIL div1_pwm c=%0d got %b want %b", c, pwm1, ep); end
      vec++; if (wrap1 !== ew) begin err++; $display("FAIL div1_wrap c=%0d got %b want %b", c, wrap1, ew); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_midchange;
    test_pause;
    test_async_reset;
    test_div1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pwm_slow_gen.md
Name: pwm_slow_gen

Overview:
- Prescaled PWM generator.
- An internal prescaler divides the system clock into a one-cycle slow tick (clock enable, not a derived clock).
- A PWM period counter advances on each slow tick and is compared against a duty input to drive a registered PWM output.
- Sits between system clock/reset and a board-level output pin (LED/motor driver); all logic is in the clk domain.

Parameters:
- DIV, 4, prescaler ratio; slow tick every DIV clk cycles; legal range >= 1.
- PERIOD, 16, PWM period in slow ticks; legal range >= 2.
- DUTY_W, $clog2(PERIOD+1), width of duty input (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_i  input  1  run enable; low freezes counters and forces pwm_o low.
- duty_i  input  DUTY_W  high time in slow ticks, 0..PERIOD.
- pwm_o  output  1  registered PWM output.
- tick_o  output  1  slow tick strobe, one clk cycle wide.
- wrap_o  output  1  strobe on the tick where the period counter wraps PERIOD-1 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler = 0, period counter = 0, active duty register = 0, pwm_o = 0, tick_o = 0, wrap_o = 0.
- Prescaler
  - Counts 0..DIV-1 while en_i = 1.
  - At count DIV-1 it returns to 0, and tick_o is registered high for exactly the next cycle.
  - DIV = 1 gives tick_o high every cycle while enabled.
- Period counter
  - Increments by 1 on each cycle where the internal tick is asserted; wraps PERIOD-1 -> 0.
  - wrap_o is high in the same cycle as the tick that causes the wrap.
- Output compare
  - At each clk edge, pwm_o <= en_i && (period counter < active duty), using register values before the edge.
  - Latency: pwm_o lags the counter by one clk cycle.
  - High time = duty × DIV clk cycles; full PWM period = PERIOD × DIV clk cycles.
- Boundaries
  - duty 0 -> pwm_o constantly 0.
  - duty >= PERIOD -> pwm_o constantly 1 while enabled. Values above PERIOD are saturated to PERIOD.
- en_i low
  - Prescaler and period counter hold their values; tick_o = 0, wrap_o = 0.
  - pwm_o = 0 from the next edge.
  - On re-enable, counting resumes from the held values (no restart).
- Reset mid-period: all state returns to reset values immediately; counting restarts from 0 after rst_n rises (first tick DIV cycles after release).
- Duty changes take effect per the Optional Feature rule.

Optional Feature:
- Macro: PWM_SHADOW_EN.
- Defined:
  - duty_i is sampled into the active duty register only on wrap cycles (and on the first enabled cycle after reset), so every period is glitch-free.
  - Mid-period changes take effect at the next period start.
- Undefined:
  - Active duty = duty_i, registered every clk cycle.
  - A change affects pwm_o two cycles later, even mid-period.

Decomposition:
- Shared package pwm_pkg:
  - Default constants DIV_DEF = 4 and PERIOD_DEF = 16.
  - A function computing the saturated duty.
- One sub-module slow_tick_gen (parameter DIV; ports clk, rst_n, en_i, tick_o) holding the prescaler.
- The period counter, compare and shadow logic stay in pwm_slow_gen.

Test Plan:
- Reset release, en_i = 1, duty 8, defaults -> tick_o every 4 clk; pwm_o high 32 clk then low 32 clk; 64-clk period; wrap_o every 64 clk.
- duty 0 for 200 clk, then duty 16 (also try 20) -> pwm_o stays 0, then stays 1 once the new duty is active; saturation confirmed.
- duty 4 -> 12 at mid-period:
  - With PWM_SHADOW_EN, the current period keeps 16-clk high time and the next period has 48-clk high time.
  - Without it, the change is visible within 2 clk.
- en_i low for 50 clk mid-period -> tick_o/wrap_o silent, pwm_o 0, counters held; after re-enable the remaining period length equals the pre-pause remainder.
- Assert rst_n low asynchronously (between clk edges) mid-high-phase -> pwm_o and tick_o drop immediately; after release, first tick_o at clk 4.
- DIV = 1, PERIOD = 2, duty 1 -> pwm_o toggles every clk cycle (50% at clk/2).
